int_to_fp_seq: RTL and testbench

- Sequential integer-to-IEEE754 converter that produces packed FP words in the `(NX, NM)` format family handled by the FP format converter.
- Sits directly upstream of that converter: the output word feeds the converter's input with `INX=NX`, `INM=NM`.
- Multi-cycle iterative normaliser with valid/ready handshakes on both sides, so a stream of integers can be pushed into the FP datapath.

---
 rtl/int_to_fp_seq_pkg.sv | 18 +
 rtl/fp_round_ne.sv | 46 ++++
 rtl/int_to_fp_seq.sv | 126 ++++++++++++
 tb/tb_int_to_fp_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_to_fp_seq_pkg.sv
// Shared definitions for the integer-to-FP front end.
//   state_t    : converter FSM states
//   exp_offset : IEEE754 exponent bias for an NX-bit exponent field
package int_to_fp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bias = 2^(nx-1) - 1 (127 for binary32, 1023 for binary64).
    function automatic int exp_offset(input int nx);
        return (1 << (nx - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_round_ne.sv
// Combinational round-to-nearest-even packer.
//   frac  : normalised magnitude with the leading one stripped (IW-1 bits)
//   e     : biased exponent that goes with the leading one
//   sign  : result sign
//   word  : packed {sign, exp, mant} after rounding (not saturated)
//   ovf   : rounded exponent does not fit; caller substitutes infinity
module fp_round_ne #(
    parameter int IW = 32,
    parameter int NX = 8,
    parameter int NM = 23,
    parameter int EW = 15
) (
    input  logic [IW-2:0]   frac,
    input  logic [EW-1:0]   e,
    input  logic            sign,
    output logic [NX+NM:0]  word,
    output logic            ovf
);

    // Pad with NM+2 zeros so mantissa, guard and sticky always exist,
    // whichever of IW-1 and NM is larger.
    localparam int W = IW + NM + 1;
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << NX) - 1);

    logic [W-1:0]  ext;
    logic [NM-1:0] m;
    logic          guard;
    logic          sticky;
    logic          inc;
    logic [NM:0]   m_inc;
    logic [EW-1:0] e_fin;

    always_comb begin
        ext    = {frac, {(NM + 2){1'b0}}};
        m      = ext[W-1 -: NM];
        guard  = ext[W-1-NM];
        sticky = |ext[W-2-NM:0];
        inc    = guard & (sticky | m[0]);
        m_inc  = {1'b0, m} + {{NM{1'b0}}, inc};
        // Carry out of the mantissa leaves m_inc[NM-1:0] == 0 already.
        e_fin  = e + {{(EW-1){1'b0}}, m_inc[NM]};
        ovf    = (e_fin >= EXP_MAX);
        word   = {sign, e_fin[NX-1:0], m_inc[NM-1:0]};
    end

endmodule

// File: rtl/int_to_fp_seq.sv
// Iterative integer -> IEEE754 (NX exponent, NM mantissa bits) converter.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake, in_data is the integer operand
//   out_valid/out_ready : output handshake, out_data = {sign, exp, mant}
// Normalises one bit per cycle, then rounds to nearest-even in one cycle.
module int_to_fp_seq
    import int_to_fp_seq_pkg::*;
#(
    parameter int IW     = 32,
    parameter int SIGNED = 1,
    parameter int NX     = 8,
    parameter int NM     = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NX+NM:0]  out_data
);

    if (IW < 2 || NX < 2) begin : g_bad_param
        $error("int_to_fp_seq: IW and NX must both be >= 2");
    end

    // Headroom for BIAS + IW plus the rounding carry.
    localparam int            EW     = NX + $clog2(IW) + 2;
    localparam logic [EW-1:0] E_INIT = EW'(exp_offset(NX) + IW - 1);

    state_t          state, state_n;
    logic [IW-1:0]   mag, mag_n;
    logic [EW-1:0]   e, e_n;
    logic            sign, sign_n;
    logic [NX+NM:0]  out_data_n;
    logic            out_valid_n;
    logic            in_ready_n;
    logic            neg;
    logic [IW-1:0]   abs_in;
    logic [NX+NM:0]  rnd_word;
    logic            rnd_ovf;

    fp_round_ne #(.IW(IW), .NX(NX), .NM(NM), .EW(EW)) u_round (
        .frac (mag[IW-2:0]),
        .e    (e),
        .sign (sign),
        .word (rnd_word),
        .ovf  (rnd_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mag       <= '0;
            e         <= '0;
            sign      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_n;
            mag       <= mag_n;
            e         <= e_n;
            sign      <= sign_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            in_ready  <= in_ready_n;
        end
    end

    always_comb begin
        state_n     = state;
        mag_n       = mag;
        e_n         = e;
        sign_n      = sign;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        // Two's-complement negate wraps the most-negative value onto 2^(IW-1).
        neg         = (SIGNED != 0) && in_data[IW-1];
        abs_in      = neg ? (~in_data + 1'b1) : in_data;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    mag_n = abs_in;
                    e_n   = E_INIT;
                    if (abs_in == '0) begin
                        sign_n     = 1'b0;
                        out_data_n = '0;
                        state_n    = DONE;
                    end else begin
                        sign_n  = neg;
                        state_n = NORM;
                    end
                end
            end
            NORM: begin
                if (mag[IW-1]) begin
                    state_n = ROUND;
                end else begin
                    mag_n = mag << 1;
                    e_n   = e - 1'b1;
                end
            end
            ROUND: begin
                out_data_n  = rnd_ovf ? {sign, {NX{1'b1}}, {NM{1'b0}}} : rnd_word;
                out_valid_n = 1'b1;
                state_n     = DONE;
            end
            DONE: begin
                // Zero results enter DONE with out_valid low; raise it here.
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end else begin
                    out_valid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        in_ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_int_to_fp_seq.sv
module tb_int_to_fp_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic        in_valid_u, in_ready_u, out_valid_u, out_ready_u;
    logic [31:0] in_data_u, out_data_u;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    int_to_fp_seq #(.IW(32), .SIGNED(1), .NX(8), .NM(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    int_to_fp_seq #(.IW(32), .SIGNED(0), .NX(8), .NM(23)) dut_u (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_u), .in_ready(in_ready_u), .in_data(in_data_u),
        .out_valid(out_valid_u), .out_ready(out_ready_u), .out_data(out_data_u)
    );

    // ---------------- reference model ----------------
    function automatic longint unsigned ref_mag(input logic [31:0] x, input bit sgn);
        if (sgn && x[31]) return (64'd1 << 32) - {32'd0, x};
        return {32'd0, x};
    endfunction

    function automatic int msb_pos(input longint unsigned m);
        int p = -1;
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        return p;
    endfunction

    function automatic logic [31:0] ref_conv(input logic [31:0] x, input bit sgn);
        longint unsigned m, q, rem, half;
        int p, sh, ex;
        bit s;
        m = ref_mag(x, sgn);
        if (m == 0) return 32'h0;
        s  = sgn && x[31];
        p  = msb_pos(m);
        ex = 127 + p;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q  = q >> 1;
                ex = ex + 1;
            end
        end
        return {s, ex[7:0], q[22:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] x, input bit sgn);
        longint unsigned m = ref_mag(x, sgn);
        if (m == 0) return 1;
        return (31 - msb_pos(m)) + 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL spurious_out: got %h expected no result", out_data);
            end else begin
                chk("out_data", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    int exp_lat;

    task automatic accept(input logic [31:0] x);
        int n = 0;
        in_valid = 1'b1;
        in_data  = x;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk);
        exp_q.push_back(ref_conv(x, 1'b1));
        exp_lat = ref_lat(x, 1'b1);
        #1;
        // Junk while busy: must be ignored.
        in_valid = 1'($urandom % 2);
        in_data  = $urandom;
    endtask

    task automatic wait_out();
        int lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 100) break;
            lat++;
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic release_out(input int hold, input bit keep, input logic [31:0] nxt);
        in_valid = keep;
        in_data  = nxt;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            chk("out_valid_held", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
        chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic conv(input logic [31:0] x);
        accept(x);
        wait_out();
        release_out($urandom_range(0, 2), 1'b0, 32'd0);
    endtask

    task automatic conv_u(input logic [31:0] x);
        int n = 0;
        in_valid_u = 1'b1;
        in_data_u  = x;
        do begin @(negedge clk); n++; end while (!in_ready_u && n < 200);
        @(posedge clk);
        #1 in_valid_u = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid_u && n < 100);
        chk("unsigned_out", out_data_u, out_valid_u ? ref_conv(x, 1'b0) : ~ref_conv(x, 1'b0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] x;
        logic [31:0] dir [7];
        dir = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd16777217, 32'd16777219};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid_u = 1'b0; in_data_u = '0; out_ready_u = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("in_ready_rise", {31'd0, in_ready}, 32'd1);

        // Pin the model to hand-computed values.
        chk("pin_1",        ref_conv(32'd1, 1'b1),           32'h3F80_0000);
        chk("pin_m1",       ref_conv(32'hFFFF_FFFF, 1'b1),   32'hBF80_0000);
        chk("pin_0",        ref_conv(32'd0, 1'b1),           32'h0000_0000);
        chk("pin_minneg",   ref_conv(32'h8000_0000, 1'b1),   32'hCF00_0000);
        chk("pin_maxpos",   ref_conv(32'h7FFF_FFFF, 1'b1),   32'h4F00_0000);
        chk("pin_tie_even", ref_conv(32'd16777217, 1'b1),    32'h4B80_0000);
        chk("pin_tie_up",   ref_conv(32'd16777219, 1'b1),    32'h4B80_0002);
        chk("pin_5",        ref_conv(32'd5, 1'b1),           32'h40A0_0000);
        chk("pin_u_max",    ref_conv(32'hFFFF_FFFF, 1'b0),   32'h4F80_0000);
        chk("pin_lat_1",    ref_lat(32'd1, 1'b1),            32'd33);

        foreach (dir[i]) conv(dir[i]);

        // Backpressure with the next word already waiting.
        accept(32'h0001_2345);
        wait_out();
        release_out(5, 1'b1, 32'hFFFF_FF00);
        accept(32'hFFFF_FF00);
        wait_out();
        release_out(0, 1'b0, 32'd0);

        for (int i = 0; i < 40; i++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom % 2) x = -x;
            if ($urandom % 16 == 0) x = 32'd0;
            conv(x);
        end

        // Asynchronous reset mid-normalisation.
        accept(32'd1);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst_rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_rel_out_valid", {31'd0, out_valid}, 32'd0);
        conv(32'd5);

        // Unsigned instance.
        conv_u(32'hFFFF_FFFF);
        conv_u(32'h8000_0000);
        conv_u(32'd16777219);
        conv_u($urandom);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
